// File: rtl/gf2m_409_reduce.sv
// Reduces an 818-bit carry-less product modulo x^409 + x^87 + 1 by iterative folding.
// Latency: NFOLD fold cycles after the accept edge, then result held in DONE (period NFOLD+1).
// Backpressure: result held stable until out_ready; a new operand is taken in the same cycle it is released.
module gf2m_409_reduce #(
  parameter int M     = 409,
  parameter int K     = 87,
  parameter int NFOLD = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*M-1:0] in_c,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M-1:0]   out_r,
  output logic           busy
);

  localparam int CW = $clog2(NFOLD + 1);

  typedef enum logic [1:0] {IDLE, FOLD, DONE} state_t;

  state_t         state_q, state_d;
  logic [2*M-1:0] t_q, t_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   out_r_q, out_r_d;
  logic           en_q;

  logic [M-1:0]   hi;
  logic [2*M-1:0] folded;
  logic           accept;

  // One fold: x^M == x^K + 1, so the upper half is folded down at bit 0 and bit K.
  always_comb begin
    hi     = t_q[2*M-1:M];
    folded = {{M{1'b0}}, t_q[M-1:0]} ^ {{M{1'b0}}, hi} ^ ({{M{1'b0}}, hi} << K);
  end

  // en_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = ((state_q == IDLE) && en_q) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_r     = out_r_q;

  // Next-state and datapath: load on accept, fold NFOLD times, publish low half in DONE.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    out_r_d = out_r_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          t_d     = in_c;
          cnt_d   = '0;
          state_d = FOLD;
        end
      end
      FOLD: begin
        t_d   = folded;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NFOLD - 1)) begin
          out_r_d = folded[M-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            t_d     = in_c;
            cnt_d   = '0;
            state_d = FOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      cnt_q   <= '0;
      out_r_q <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      out_r_q <= out_r_d;
      en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gf2m_409_reduce.sv
// Directed bench for gf2m_409_reduce: hand-computed vectors plus a software clmul/mod reference.
module tb_gf2m_409_reduce;

  localparam int M  = 409;
  localparam int W2 = 2 * M;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W2-1:0] in_c;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out_r;
  logic          busy;

  int n_assert;
  int n_fail;

  gf2m_409_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W2-1:0] obs, input logic [W2-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_inv(input string tag);
    chk(tag, W2'(dut.t_q[W2-1:M]), '0);
  endtask

  function automatic logic [W2-1:0] clmul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [W2-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++)
      if (b[i]) r = r ^ (W2'(a) << i);
    return r;
  endfunction

  function automatic logic [M-1:0] polymod(input logic [W2-1:0] c);
    logic [W2-1:0] r;
    logic [W2-1:0] p;
    r = c;
    p = (W2'(1) << 409) | (W2'(1) << 87) | W2'(1);
    for (int i = W2 - 1; i >= M; i--)
      if (r[i]) r = r ^ (p << (i - M));
    return r[M-1:0];
  endfunction

  function automatic logic [M-1:0] rand_elem();
    logic [415:0] tmp;
    for (int w = 0; w < 13; w++) tmp[w*32 +: 32] = $urandom;
    return tmp[M-1:0];
  endfunction

  // Single operation from IDLE with out_ready low until the result shows.
  task automatic run_one(input logic [W2-1:0] c, input logic [M-1:0] exp, input string tag);
    in_c      = c;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk({tag, ".in_ready"}, W2'(in_ready), W2'(1));
    tick();
    in_valid = 1'b0;
    in_c     = '1;
    chk({tag, ".busy1"}, W2'(busy), W2'(1));
    chk({tag, ".ov1"}, W2'(out_valid), '0);
    tick();
    chk({tag, ".ov2"}, W2'(out_valid), '0);
    tick();
    chk({tag, ".ov3"}, W2'(out_valid), W2'(1));
    chk({tag, ".busy3"}, W2'(busy), W2'(1));
    chk({tag, ".out_r"}, W2'(out_r), W2'(exp));
    chk_inv({tag, ".inv"});
    out_ready = 1'b1;
    tick();
    chk({tag, ".ov_after"}, W2'(out_valid), '0);
    chk({tag, ".busy_after"}, W2'(busy), '0);
    out_ready = 1'b0;
  endtask

  logic [W2-1:0] ops  [10];
  logic [M-1:0]  exps [10];
  logic [M-1:0]  ra, rb;
  logic [M-1:0]  bp_exp;

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_c      = '0;

    // Reset state
    #2;
    chk("rst.out_valid", W2'(out_valid), '0);
    chk("rst.out_r", W2'(out_r), '0);
    chk("rst.busy", W2'(busy), '0);
    chk("rst.in_ready", W2'(in_ready), '0);
    tick();
    chk("rst.in_ready_held", W2'(in_ready), '0);
    rst = 1'b1;
    tick();
    chk("rel.in_ready", W2'(in_ready), W2'(1));
    chk("rel.busy", W2'(busy), '0);

    // out_ready with nothing pending does nothing
    out_ready = 1'b1;
    tick();
    chk("idle_ordy.ov", W2'(out_valid), '0);
    chk("idle_ordy.busy", W2'(busy), '0);
    out_ready = 1'b0;

    // Directed vectors
    run_one(W2'(5), M'(5), "v5");
    run_one(W2'(1) << 409, (M'(1) << 87) | M'(1), "x409");
    run_one((W2'(1) << 409) | W2'(5), (M'(1) << 87) | M'(4), "x409p5");
    run_one(W2'(1) << 495, (M'(1) << 173) | (M'(1) << 86), "x495");
    run_one(W2'(1) << 817, (M'(1) << 408) | (M'(1) << 173) | (M'(1) << 86), "x817");

    // Back-to-back random products, in_valid held high throughout
    for (int k = 0; k < 10; k++) begin
      ra      = rand_elem();
      rb      = rand_elem();
      ops[k]  = clmul(ra, rb);
      exps[k] = polymod(ops[k]);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_c      = ops[0];
    tick();
    for (int k = 0; k < 10; k++) begin
      in_c     = (k < 9) ? ops[k+1] : '0;
      in_valid = (k < 9);
      chk("b2b.ov_f1", W2'(out_valid), '0);
      tick();
      chk("b2b.ov_f2", W2'(out_valid), '0);
      tick();
      chk("b2b.ov", W2'(out_valid), W2'(1));
      chk("b2b.out_r", W2'(out_r), W2'(exps[k]));
      chk_inv("b2b.inv");
      tick();
    end
    chk("b2b.idle", W2'(busy), '0);
    out_ready = 1'b0;

    // Backpressure: hold DONE for 7 cycles, then release with next operand waiting
    bp_exp   = (M'(1) << 87) | M'(1);
    in_c     = W2'(1) << 409;
    in_valid = 1'b1;
    tick();
    in_c = W2'(1) << 817;
    tick();
    tick();
    chk("bp.ov", W2'(out_valid), W2'(1));
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("bp.hold_ov", W2'(out_valid), W2'(1));
      chk("bp.hold_r", W2'(out_r), W2'(bp_exp));
      chk("bp.hold_ir", W2'(in_ready), '0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.ir_comb", W2'(in_ready), W2'(1));
    tick();
    in_valid = 1'b0;
    in_c     = '0;
    chk("bp.next_ov", W2'(out_valid), '0);
    chk("bp.next_busy", W2'(busy), W2'(1));
    tick();
    tick();
    chk("bp.next_ov2", W2'(out_valid), W2'(1));
    chk("bp.next_r", W2'(out_r), W2'((M'(1) << 408) | (M'(1) << 173) | (M'(1) << 86)));
    chk_inv("bp.inv");
    tick();
    chk("bp.idle", W2'(busy), '0);
    out_ready = 1'b0;

    // Reset during FOLD discards the operation
    in_c     = W2'(1) << 600;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("mid.ov", W2'(out_valid), '0);
    chk("mid.busy", W2'(busy), '0);
    chk("mid.ir", W2'(in_ready), '0);
    chk("mid.out_r", W2'(out_r), '0);
    tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("mid.rel_ir", W2'(in_ready), W2'(1));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid.no_out", W2'(out_valid), '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
